fpu_op_sequencer: RTL

Control FSM between the operation command FIFO and the shared floating-point datapath (add/sub/mul units) in the FPU wrapper. It takes one queued command at a time, latches its operands, and starts the selected unit. It then waits for completion, or times out, and pushes exactly one 32-bit result per command into the result FIFO. Commands complete strictly in order, one in flight.

---
 rtl/fpu_ctrl_pkg.sv | 30 +++
 rtl/fpu_op_sequencer_if.sv | 39 +++
 rtl/fpu_watchdog.sv | 41 ++++
 rtl/fpu_op_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU operation sequencer.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_MUL = 3'b011
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_WRITE = 2'b11
    } state_e;

    localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
    localparam int unsigned TIMEOUT_DEFAULT = 32'd64;

    // True for the opcodes the datapath implements; everything else is turned into a qNaN result.
    function automatic logic is_legal_op(input logic [2:0] sel);
        logic legal;
        case (sel)
            OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Command FIFO, datapath and result FIFO signals of the FPU operation sequencer.
interface fpu_op_sequencer_if;

    logic        cmd_empty;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic [2:0]  cmd_sel;
    logic        cmd_pop;

    logic        unit_start;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [2:0]  unit_sel;
    logic        unit_done;
    logic [31:0] unit_result;

    logic        res_full;
    logic        res_push;
    logic [31:0] res_data;

    logic        busy;
    logic        err;
    logic [7:0]  ops_done;

    // Sequencer side
    modport master (
        input  cmd_empty, cmd_op1, cmd_op2, cmd_sel, unit_done, unit_result, res_full,
        output cmd_pop, unit_start, unit_a, unit_b, unit_sel, res_push, res_data,
        output busy, err, ops_done
    );

    // FIFO / datapath side
    modport slave (
        output cmd_empty, cmd_op1, cmd_op2, cmd_sel, unit_done, unit_result, res_full,
        input  cmd_pop, unit_start, unit_a, unit_b, unit_sel, res_push, res_data,
        input  busy, err, ops_done
    );

endinterface

// File: rtl/fpu_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the datapath.
module fpu_watchdog #(
    parameter int unsigned TIMEOUT = 32'd64
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Expiry is flagged in the last allowed wait cycle so the error result lands on time.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 32'd1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear has priority over counting, otherwise hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one queued FP command at a time to the shared datapath and pushes exactly one result per command.
module fpu_op_sequencer
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               n_rst,
    fpu_op_sequencer_if.master bus
);

    state_e      state_q,  state_d;
    logic [31:0] op_a_q,   op_a_d;
    logic [31:0] op_b_q,   op_b_d;
    logic [2:0]  sel_q,    sel_d;
    logic [31:0] result_q, result_d;
    logic        err_q,    err_d;
    logic [7:0]  ops_q,    ops_d;

    logic pop_s;
    logic start_s;
    logic push_s;
    logic wd_clr_s;
    logic wd_en_s;
    logic wd_expired_s;

    fpu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (wd_clr_s),
        .en_i      (wd_en_s),
        .expired_o (wd_expired_s)
    );

    // Next state, register loads and one-cycle handshake strobes
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sel_d    = sel_q;
        result_d = result_q;
        err_d    = err_q;
        ops_d    = ops_q;
        pop_s    = 1'b0;
        start_s  = 1'b0;
        push_s   = 1'b0;
        wd_clr_s = 1'b0;
        wd_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.cmd_empty) begin
                    pop_s  = 1'b1;
                    op_a_d = bus.cmd_op1;
                    op_b_d = bus.cmd_op2;
                    sel_d  = bus.cmd_sel;
                    if (is_legal_op(bus.cmd_sel)) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Illegal opcode never reaches the datapath
                        result_d = FP_QNAN;
                        err_d    = 1'b1;
                        state_d  = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                start_s  = 1'b1;
                wd_clr_s = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wd_en_s = 1'b1;
                // A completion in the expiry cycle still counts as success
                if (bus.unit_done) begin
                    result_d = bus.unit_result;
                    state_d  = S_WRITE;
                end else if (wd_expired_s) begin
                    result_d = FP_QNAN;
                    err_d    = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                if (!bus.res_full) begin
                    push_s  = 1'b1;
                    ops_d   = ops_q + 8'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            sel_q    <= 3'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            ops_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            err_q    <= err_d;
            ops_q    <= ops_d;
        end
    end

    // Strobes are masked during reset so no command is lost or result emitted while the state is discarded
    assign bus.cmd_pop    = pop_s   & n_rst;
    assign bus.unit_start = start_s & n_rst;
    assign bus.res_push   = push_s  & n_rst;
    assign bus.unit_a     = op_a_q;
    assign bus.unit_b     = op_b_q;
    assign bus.unit_sel   = sel_q;
    assign bus.res_data   = result_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.err        = err_q;
    assign bus.ops_done   = ops_q;

endmodule
